spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//  SPI slave front end for the single-port SPI RAM. Deserialises MOSI into 10-bit
//  command words {cmd[1:0],payload[7:0]} and presents them on rx_data/rx_valid.
//  Serialises the RAM's read byte (tx_data/tx_valid) back onto MISO, MSB first.
//  Sits between the SPI pins and the RAM. SPI bit timing is the system clock clk.
// PARAMETERS
//  DATA_W  8  payload/read-data width; rx word width = DATA_W+2
// PORTS
//  clk       in   1         system clock = SPI bit clock; all logic on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  SS_n      in   1         slave select, active low; high = frame abort/end
//  MOSI      in   1         serial data in, sampled on rising clk, MSB first
//  MISO      out  1         serial data out, registered
//  rx_data   out  DATA_W+2  last complete received word {cmd,payload}
//  rx_valid  out  1         one-cycle pulse: rx_data holds a new word
//  tx_data   in   DATA_W    read byte from RAM
//  tx_valid  in   1         tx_data valid (level)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit_cnt=0,
//   rd_addr_ok=0, tx shift reg=0.
//  States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
//  Any edge with SS_n=1 -> IDLE; bit_cnt=0, MISO=0, rx_valid=0; rx_data and
//   rd_addr_ok keep their values. An abort mid-word never pulses rx_valid.
//  Edge numbering: edge 0 = first edge with SS_n=0 in IDLE.
//  IDLE: SS_n=0 -> CHK_CMD (MOSI ignored on edge 0).
//  CHK_CMD (edge 1): MOSI = word bit 9, shifted in; bit_cnt=1.
//   MOSI=0 -> WRITE. MOSI=1 and rd_addr_ok=0 -> READ_ADD. MOSI=1 and rd_addr_ok=1 -> READ_DATA.
//  Edges 2..10: shift in bits 8..0. On edge 10, rx_data<=word and rx_valid<=1 for
//   exactly one cycle. Later MOSI bits in the frame are ignored.
//  rd_addr_ok: set on edge 10 if word[9:8]=2'b10; cleared on edge 10 if 2'b11;
//   unchanged for 00/01. Decode uses the received opcode, not the state.
//  WRITE / READ_ADD: after edge 10, idle in state until SS_n=1.
//  READ_DATA: after edge 10, wait for tx_valid=1, sampled from edge 11 on. On the
//   first such edge, load tx_data and drive MISO<=tx_data[DATA_W-1]. On the next
//   DATA_W-1 edges, shift out the remaining bits MSB->LSB. On the following edge,
//   MISO<=0 and stay done until SS_n=1 (one byte per frame).
//  Paired with the RAM (tx_valid registered one cycle after rx_valid): tx load on
//   edge 12, MISO=bit7 after edge 12, bit0 after edge 19, 0 after edge 20.
//  tx_valid outside READ_DATA is ignored.
//  rx_data is stable between pulses (the RAM decodes din continuously).
// TESTING
//  Reset mid-frame: rst_n low at edge 5 -> all outputs 0 at once; no rx_valid.
//  Write addr: frame 00_0x3C -> rx_valid 1 cycle after edge 10, rx_data=10'h03C;
//   then frame 01_0xA5 -> rx_data=10'h1A5.
//  Read addr: frame 10_0x3C -> rx_data=10'h23C, rd_addr_ok=1, MISO stays 0.
//  Read data: frame 11_0x00, RAM model returns 8'hA5 -> rx_data=10'h300; MISO
//   bits 1,0,1,0,0,1,0,1 after edges 12..19; rd_addr_ok=0; MISO 0 after edge 20.
//  Abort: SS_n high after 6 bits -> IDLE next edge, no rx_valid, rx_data unchanged;
//   the next full frame decodes correctly.
//  Read without address (rd_addr_ok=0): bit9=1 enters READ_ADD; word 11_xx still
//   pulses rx_valid, clears rd_addr_ok, and drives no MISO data.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit {cmd,payload} words from MOSI and
// serialises one RAM read byte per frame onto MISO, MSB first.
module spi_slave_if #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int unsigned WordW  = DATA_W + 2;
  localparam int unsigned CntW   = $clog2(WordW + 1);
  localparam int unsigned TxCntW = $clog2(DATA_W + 2);

  typedef enum logic [2:0] {StIdle, StChkCmd, StWrite, StReadAdd, StReadData} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WordW-2:0]  shift_q, shift_d;
  logic [WordW-1:0]  rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rd_addr_ok_q, rd_addr_ok_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
  logic              miso_q, miso_d;
  logic [WordW-1:0]  word;
  logic              word_done;

  // shift_q already holds bits 9..1 when the last bit arrives on MOSI
  assign word      = {shift_q, MOSI};
  assign word_done = (bit_cnt_q == CntW'(WordW - 1));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rd_addr_ok_d = rd_addr_ok_q;
    tx_shift_d   = tx_shift_q;
    tx_cnt_d     = tx_cnt_q;
    miso_d       = miso_q;

    if (SS_n) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      miso_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StChkCmd;
          bit_cnt_d = '0;
          tx_cnt_d  = '0;
        end
        StChkCmd: begin
          shift_d   = {shift_q[WordW-3:0], MOSI};
          bit_cnt_d = CntW'(1);
          if (!MOSI)             state_d = StWrite;
          else if (rd_addr_ok_q) state_d = StReadData;
          else                   state_d = StReadAdd;
        end
        StWrite, StReadAdd, StReadData: begin
          if (bit_cnt_q < CntW'(WordW)) begin
            shift_d   = {shift_q[WordW-3:0], MOSI};
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (word_done) begin
              rx_data_d  = word;
              rx_valid_d = 1'b1;
              // 10 arms the next read frame, 11 consumes it
              if (word[WordW-1]) rd_addr_ok_d = ~word[WordW-2];
            end
          end else if (state_q == StReadData) begin
            // tx_cnt: 0 waiting, 1..DATA_W-1 shifting, DATA_W last bit out, DATA_W+1 done
            if (tx_cnt_q == '0) begin
              if (tx_valid) begin
                miso_d     = tx_data[DATA_W-1];
                tx_shift_d = {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt_d   = TxCntW'(1);
              end
            end else if (tx_cnt_q < TxCntW'(DATA_W)) begin
              miso_d     = tx_shift_q[DATA_W-1];
              tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
              tx_cnt_d   = tx_cnt_q + TxCntW'(1);
            end else if (tx_cnt_q == TxCntW'(DATA_W)) begin
              miso_d   = 1'b0;
              tx_cnt_d = TxCntW'(DATA_W + 1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_ok_q <= 1'b0;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      miso_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rd_addr_ok_q <= rd_addr_ok_d;
      tx_shift_q   <= tx_shift_d;
      tx_cnt_q     <= tx_cnt_d;
      miso_q       <= miso_d;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised scoreboard bench for spi_slave_if with a small RAM stub and a
// frame-level reference model of the expected pin activity.
module tb_spi_slave_if;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n, SS_n, MOSI, MISO, rx_valid, tx_valid, noise;
  logic [DATA_W+1:0] rx_data;
  logic [DATA_W-1:0] tx_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       miso;
    logic       vld;
    logic [9:0] data;
  } exp_t;

  exp_t       edge_q[$];
  logic [9:0] rx_q[$];
  exp_t       mon_e;
  logic [9:0] mon_w;

  // reference model state
  logic [7:0] m_mem[256];
  logic [7:0] m_waddr, m_raddr;
  logic       m_rd_ok;
  logic [9:0] m_last_rx;

  // RAM stub state
  logic [7:0] s_mem[256];
  logic [7:0] s_waddr, s_raddr;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  // RAM stub: tx_valid is registered one cycle after a read-data command pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
      s_waddr  <= '0;
      s_raddr  <= '0;
      for (int i = 0; i < 256; i++) s_mem[i] <= 8'(i * 37 + 11);
    end else begin
      tx_valid <= noise;
      if (rx_valid) begin
        case (rx_data[9:8])
          2'b00: s_waddr <= rx_data[7:0];
          2'b01: s_mem[s_waddr] <= rx_data[7:0];
          2'b10: s_raddr <= rx_data[7:0];
          default: begin
            tx_data  <= s_mem[s_raddr];
            tx_valid <= 1'b1;
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_rd_ok   = 1'b0;
    m_last_rx = '0;
    m_waddr   = '0;
    m_raddr   = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i * 37 + 11);
  endtask

  // Drive one clock edge's inputs and queue what the pins must show after it.
  task automatic step(input logic ss, input logic mosi, input logic nz, input logic em,
                      input logic ev, input logic [9:0] ed);
    exp_t e;
    @(negedge clk);
    SS_n  = ss;
    MOSI  = mosi;
    noise = nz;
    e.miso = em;
    e.vld  = ev;
    e.data = ed;
    edge_q.push_back(e);
  endtask

  // One frame: n_low edges with SS_n low (edge 0 first), then two edges high.
  task automatic run_frame(input logic [9:0] word, input int n_low);
    logic       rd_frame, mosi, em;
    logic [7:0] rbyte;
    rd_frame = (word[9:8] == 2'b11) && m_rd_ok;
    rbyte    = m_mem[m_raddr];
    for (int k = 0; k < n_low; k++) begin
      mosi = (k >= 1 && k <= 10) ? word[10-k] : 1'($urandom);
      em   = 1'b0;
      if (rd_frame && k >= 12 && k <= 19) em = rbyte[19-k];
      if (k == 10) begin
        m_last_rx = word;
        rx_q.push_back(word);
        case (word[9:8])
          2'b00: m_waddr = word[7:0];
          2'b01: m_mem[m_waddr] = word[7:0];
          2'b10: begin m_raddr = word[7:0]; m_rd_ok = 1'b1; end
          default: m_rd_ok = 1'b0;
        endcase
      end
      step(1'b0, mosi, !word[9] && 1'($urandom), em, k == 10, m_last_rx);
    end
    repeat (2) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, m_last_rx);
  endtask

  // monitor: per-edge pin expectations plus received-word scoreboard
  always begin
    @(posedge clk);
    #1;
    if (rst_n && edge_q.size() > 0) begin
      mon_e = edge_q.pop_front();
      chk("miso", 32'(MISO), 32'(mon_e.miso));
      chk("rx_valid", 32'(rx_valid), 32'(mon_e.vld));
      chk("rx_data", 32'(rx_data), 32'(mon_e.data));
    end
    if (rst_n && rx_valid) begin
      chk("rx_word_expected", 32'(rx_q.size() != 0), 32'd1);
      if (rx_q.size() != 0) begin
        mon_w = rx_q.pop_front();
        chk("rx_word", 32'(rx_data), 32'(mon_w));
      end
    end
  end

  initial begin
    logic [9:0] w;
    int         n;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    noise = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    rst_n = 1'b1;

    run_frame(10'h255, 12);

    // reset asserted just before edge 5 of a frame
    w = 10'h0F0;
    for (int k = 0; k < 5; k++) step(1'b0, (k == 0) ? 1'b0 : w[10-k], 1'b0, 1'b0, 1'b0, m_last_rx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_miso", 32'(MISO), 32'd0);
    chk("midreset_rx_data", 32'(rx_data), 32'd0);
    chk("midreset_rx_valid", 32'(rx_valid), 32'd0);
    model_reset();
    SS_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_frame(10'h300, 22);  // read without address
    run_frame(10'h03C, 12);
    run_frame(10'h1A5, 14);
    run_frame(10'h23C, 15);
    run_frame(10'h300, 23);  // byte A5 out on MISO
    run_frame(10'h2AA, 7);   // abort after 6 bits
    run_frame(10'h1C3, 11);
    run_frame(10'h300, 22);

    for (int f = 0; f < 40; f++) begin
      w = 10'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(11, 24));
      run_frame(w, n);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(rx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
